// File: rtl/tdm_channel_mux_if.sv
// Bundles the control, data and result signals of the TDM channel multiplexer.
// The master side drives channel data and control; the slave side is the mux itself.
interface tdm_channel_mux_if #(
  parameter int unsigned CH   = 8,
  parameter int unsigned W    = 4,
  parameter int unsigned SELW = 3,
  parameter int unsigned DWW  = 8
);
  logic              en;
  logic              mode;
  logic [SELW-1:0]   sel;
  logic [DWW-1:0]    dwell;
  logic [CH*W-1:0]   data_in;
  logic [W-1:0]      out_data;
  logic [SELW-1:0]   out_ch;
  logic              out_valid;
  logic              scan_wrap;
  logic              sel_err;

  modport master (
    output en, mode, sel, dwell, data_in,
    input  out_data, out_ch, out_valid, scan_wrap, sel_err
  );

  modport slave (
    input  en, mode, sel, dwell, data_in,
    output out_data, out_ch, out_valid, scan_wrap, sel_err
  );
endinterface

// File: rtl/tdm_channel_mux.sv
// Registered N-channel, W-bit multiplexer with manual select and auto-scan
// (time-division) modes; scan dwell per channel is dwell+1 cycles.
module tdm_channel_mux #(
  parameter int unsigned CH   = 8,
  parameter int unsigned W    = 4,
  parameter int unsigned SELW = 3,
  parameter int unsigned DWW  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  tdm_channel_mux_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t          state, state_n;
  logic [W-1:0]    chans [CH];
  logic [DWW-1:0]  cnt, cnt_n;
  logic [W-1:0]    data_n;
  logic [SELW-1:0] ch_n;
  logic            valid_n, wrap_n, err_n;
  logic [SELW-1:0] ch_next;
  logic            at_last, sel_ok;

  always_comb begin
    for (int unsigned k = 0; k < CH; k++) begin
      chans[k] = bus.data_in[k*W +: W];
    end
  end

  // Wrap at CH-1 rather than relying on natural SELW-bit rollover.
  assign at_last = (bus.out_ch == SELW'(CH - 1));
  assign ch_next = at_last ? '0 : bus.out_ch + 1'b1;
  assign sel_ok  = (32'(bus.sel) < CH);

  // Outputs are computed for the state being entered, giving one cycle latency.
  always_comb begin
    state_n = IDLE;
    cnt_n   = '0;
    data_n  = bus.out_data;
    ch_n    = bus.out_ch;
    valid_n = 1'b0;
    wrap_n  = 1'b0;
    err_n   = 1'b0;
    if (bus.en) begin
      state_n = bus.mode ? SCAN : MANUAL;
      valid_n = 1'b1;
      if (!bus.mode) begin
        if (sel_ok) begin
          ch_n   = bus.sel;
          data_n = chans[bus.sel];
        end else begin
          err_n = 1'b1;
        end
      end else if (state != SCAN) begin
        data_n = chans[bus.out_ch];
      end else if (cnt >= bus.dwell) begin
        ch_n   = ch_next;
        data_n = chans[ch_next];
        wrap_n = at_last;
      end else begin
        cnt_n  = cnt + 1'b1;
        data_n = chans[bus.out_ch];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      bus.out_valid <= 1'b0;
      bus.scan_wrap <= 1'b0;
      bus.sel_err   <= 1'b0;
    end else begin
      cnt           <= cnt_n;
      bus.out_data  <= data_n;
      bus.out_ch    <= ch_n;
      bus.out_valid <= valid_n;
      bus.scan_wrap <= wrap_n;
      bus.sel_err   <= err_n;
    end
  end

endmodule

// File: tb/tb_tdm_channel_mux.sv
// Bench for tdm_channel_mux: an 8-channel and a 5-channel instance checked every
// cycle against a behavioural model, plus directed literal expectations.
module tb_tdm_channel_mux;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  tdm_channel_mux_if #(.CH(8), .W(4), .SELW(3), .DWW(8)) a8 ();
  tdm_channel_mux_if #(.CH(5), .W(4), .SELW(3), .DWW(8)) a5 ();

  tdm_channel_mux #(.CH(8), .W(4), .SELW(3), .DWW(8)) d8 (.clk(clk), .rst_n(rst_n), .bus(a8));
  tdm_channel_mux #(.CH(5), .W(4), .SELW(3), .DWW(8)) d5 (.clk(clk), .rst_n(rst_n), .bus(a5));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_ch [2];
  int m_age [2];
  int m_data [2];
  bit m_scan [2];
  bit m_valid [2];
  bit m_wrap [2];
  bit m_err [2];

  function automatic int lane(input logic [31:0] din, input int k);
    return int'((din >> (4 * k)) & 32'hF);
  endfunction

  task automatic model_step(input int d, input int nch, input bit ena, input bit scan_mode,
                            input int s, input int dwl, input logic [31:0] din);
    int ch, age, data;
    bit scan, valid, wrap, err;
    ch = m_ch[d]; age = m_age[d]; scan = m_scan[d]; data = m_data[d];
    valid = 0; wrap = 0; err = 0;
    if (!ena) begin
      scan = 0; age = 0;
    end else if (!scan_mode) begin
      valid = 1; scan = 0; age = 0;
      if (s < nch) begin
        ch = s; data = lane(din, ch);
      end else begin
        err = 1;
      end
    end else begin
      valid = 1;
      if (!scan) begin
        scan = 1; age = 0;
      end else if (age >= dwl) begin
        ch = (ch + 1) % nch; age = 0; wrap = (ch == 0);
      end else begin
        age++;
      end
      data = lane(din, ch);
    end
    m_ch[d] <= ch; m_age[d] <= age; m_scan[d] <= scan; m_data[d] <= data;
    m_valid[d] <= valid; m_wrap[d] <= wrap; m_err[d] <= err;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_ch[d] <= 0; m_age[d] <= 0; m_data[d] <= 0; m_scan[d] <= 0;
        m_valid[d] <= 0; m_wrap[d] <= 0; m_err[d] <= 0;
      end
    end else begin
      model_step(0, 8, a8.en, a8.mode, int'(a8.sel), int'(a8.dwell), 32'(a8.data_in));
      model_step(1, 5, a5.en, a5.mode, int'(a5.sel), int'(a5.dwell), 32'(a5.data_in));
    end
  end

  always @(negedge clk) begin
    chk("d8.out_data",  32'(a8.out_data),  32'(m_data[0]));
    chk("d8.out_ch",    32'(a8.out_ch),    32'(m_ch[0]));
    chk("d8.out_valid", 32'(a8.out_valid), 32'(m_valid[0]));
    chk("d8.scan_wrap", 32'(a8.scan_wrap), 32'(m_wrap[0]));
    chk("d8.sel_err",   32'(a8.sel_err),   32'(m_err[0]));
    chk("d5.out_data",  32'(a5.out_data),  32'(m_data[1]));
    chk("d5.out_ch",    32'(a5.out_ch),    32'(m_ch[1]));
    chk("d5.out_valid", 32'(a5.out_valid), 32'(m_valid[1]));
    chk("d5.scan_wrap", 32'(a5.scan_wrap), 32'(m_wrap[1]));
    chk("d5.sel_err",   32'(a5.sel_err),   32'(m_err[1]));
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int wraps;
    a8.en = 0; a8.mode = 0; a8.sel = '0; a8.dwell = '0; a8.data_in = 32'hA987_6543; // ch k = k+3
    a5.en = 0; a5.mode = 0; a5.sel = '0; a5.dwell = '0; a5.data_in = 20'h54321;     // ch k = k+1
    #1 rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("lit reset valid", 32'(a8.out_valid), 32'd0);
    chk("lit reset ch",    32'(a8.out_ch),    32'd0);

    // manual select
    a8.en = 1; a8.mode = 0; a8.sel = 3'd6;
    cyc(1);
    chk("lit manual data6",  32'(a8.out_data),  32'd9);
    chk("lit manual ch6",    32'(a8.out_ch),    32'd6);
    chk("lit manual valid",  32'(a8.out_valid), 32'd1);
    a8.sel = 3'd2;
    cyc(1);
    chk("lit manual data2",  32'(a8.out_data),  32'd5);

    // scan dwell=2 from channel 0
    a8.sel = 3'd0;
    cyc(1);
    a8.mode = 1; a8.dwell = 8'd2;
    wraps = 0;
    for (int i = 0; i <= 48; i++) begin
      cyc(1);
      chk("lit scan8 ch", 32'(a8.out_ch), 32'((i / 3) % 8));
      if (a8.scan_wrap) wraps++;
    end
    chk("lit scan8 wraps", 32'(wraps), 32'd2);

    // dwell lowered mid-scan while counter=6
    a8.dwell = 8'd10;
    cyc(6);
    chk("lit dwell hold ch", 32'(a8.out_ch), 32'd0);
    a8.dwell = 8'd1;
    cyc(1);
    chk("lit dwell lower ch", 32'(a8.out_ch), 32'd1);

    // scan -> manual
    a8.mode = 0; a8.sel = 3'd3;
    cyc(1);
    chk("lit scan2man ch",   32'(a8.out_ch),   32'd3);
    chk("lit scan2man data", 32'(a8.out_data), 32'd6);

    // en dropped mid-scan, input changes while idle, then resume
    a8.mode = 1; a8.dwell = 8'd3;
    cyc(2);
    a8.en = 0;
    cyc(1);
    chk("lit idle valid", 32'(a8.out_valid), 32'd0);
    chk("lit idle data",  32'(a8.out_data),  32'd6);
    a8.data_in[12 +: 4] = 4'hF;
    cyc(2);
    chk("lit idle hold", 32'(a8.out_data), 32'd6);
    a8.en = 1;
    cyc(1);
    chk("lit resume ch",   32'(a8.out_ch),   32'd3);
    chk("lit resume data", 32'(a8.out_data), 32'hF);
    a8.data_in = 32'hA987_6543;

    // reset mid-scan at channel 5
    a8.dwell = 8'd0;
    cyc(2);
    chk("lit pre-reset ch", 32'(a8.out_ch), 32'd5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("lit async data",  32'(a8.out_data),  32'd0);
    chk("lit async ch",    32'(a8.out_ch),    32'd0);
    chk("lit async valid", 32'(a8.out_valid), 32'd0);
    chk("lit async wrap",  32'(a8.scan_wrap), 32'd0);
    chk("lit async err",   32'(a8.sel_err),   32'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    chk("lit restart ch",   32'(a8.out_ch),   32'd0);
    chk("lit restart data", 32'(a8.out_data), 32'd3);
    cyc(1);
    chk("lit restart next", 32'(a8.out_ch), 32'd1);
    a8.en = 0;

    // CH=5 scan, dwell=0
    a5.en = 1; a5.mode = 1; a5.dwell = 8'd0;
    wraps = 0;
    for (int i = 0; i <= 12; i++) begin
      cyc(1);
      chk("lit scan5 ch", 32'(a5.out_ch), 32'(i % 5));
      if (a5.scan_wrap) wraps++;
    end
    chk("lit scan5 wraps", 32'(wraps), 32'd2);

    // out-of-range manual select on CH=5
    a5.mode = 0; a5.sel = 3'd6;
    cyc(1);
    chk("lit err5 pulse", 32'(a5.sel_err),  32'd1);
    chk("lit err5 ch",    32'(a5.out_ch),   32'd2);
    chk("lit err5 data",  32'(a5.out_data), 32'd3);
    cyc(1);
    chk("lit err5 repeat", 32'(a5.sel_err), 32'd1);
    a5.sel = 3'd4;
    cyc(1);
    chk("lit sel4 err",  32'(a5.sel_err),  32'd0);
    chk("lit sel4 ch",   32'(a5.out_ch),   32'd4);
    chk("lit sel4 data", 32'(a5.out_data), 32'd5);
    a5.sel = 3'd5;
    cyc(1);
    chk("lit sel5 err", 32'(a5.sel_err), 32'd1);
    chk("lit sel5 ch",  32'(a5.out_ch),  32'd4);
    a5.en = 0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
